spi_cmd_seq: RTL and testbench
==============================

SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 SHALL have parameters, one per line:
  CMD_WIDTH, 12, width of command word driven to the SPI master.
  READ_WIDTH, 8, width of write data and read data.
  TIMEOUT_CYC, 1024, read-response timeout in clk cycles (used only with the macro in REQ-030).
REQ-002 SHALL derive ADDR_WIDTH = CMD_WIDTH-1-READ_WIDTH (3 at defaults); any parameter set with ADDR_WIDTH < 1 is illegal.
REQ-003 SHALL have ports, one per line:
  clk        in   1           single clock; all logic on the rising edge.
  rst        in   1           reset, synchronous, active-high.
  req_vld    in   1           host request valid.
  req_rdy    out  1           sequencer can accept a request.
  req_rw     in   1           1 = read, 0 = write.
  req_addr   in   ADDR_WIDTH  register address.
  req_wdata  in   READ_WIDTH  write data (ignored for reads).
  resp_vld   out  1           one-cycle completion pulse.
  resp_data  out  READ_WIDTH  read data (0 for writes).
  resp_err   out  1           read timed out.
  cmd_out    out  CMD_WIDTH   command word to SPI master.
  cmd_vld    out  1           command valid to SPI master.
  cmd_rdy    in   1           SPI master accepts command.
  read_vld   in   1           SPI master read data valid.
  read_data  in   READ_WIDTH  SPI master read data.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, RESP; all outputs registered.
REQ-011 IDLE: req_rdy=1; on req_vld&&req_rdy capture rw/addr/wdata and go to ISSUE; otherwise stay.
REQ-012 req_rdy SHALL be 0 in every state other than IDLE.
REQ-013 cmd_out SHALL equal {rw, addr, wdata} (MSB = rw); for reads the wdata field SHALL be 0.
REQ-014 ISSUE: cmd_vld=1 and cmd_out held stable until cmd_vld&&cmd_rdy; cmd_vld SHALL NOT drop before the handshake.
REQ-015 On the handshake, cmd_vld SHALL be 0 the next cycle; write goes to RESP, read goes to WAIT_RD.
REQ-016 WAIT_RD: on read_vld capture read_data into resp_data and go to RESP.
REQ-017 read_vld in any state other than WAIT_RD SHALL be ignored.
REQ-018 RESP: resp_vld=1 for exactly one cycle, then IDLE; resp_data = captured read data (reads) or 0 (writes).
REQ-019 Latency, write with cmd_rdy=1: request accepted at edge N; cmd_vld=1 in cycle N+1; resp_vld=1 in cycle N+2; req_rdy=1 again in cycle N+3.
REQ-020 Latency, read: resp_vld SHALL assert the cycle after the cycle in which read_vld=1 in WAIT_RD.
REQ-021 resp_data and resp_err SHALL hold their value until the next RESP.

Reset
REQ-025 When rst=1 at a rising edge, the FSM SHALL go to IDLE regardless of state, including mid-ISSUE and WAIT_RD.
REQ-026 Reset values: req_rdy=0 during reset and 1 in the first cycle after reset deasserts; cmd_vld=0, cmd_out=0, resp_vld=0, resp_data=0, resp_err=0.
REQ-027 A request in flight at reset SHALL be discarded with no resp_vld.

Configuration
REQ-030 With macro SPI_CMD_SEQ_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_RD; if read_vld has not arrived after TIMEOUT_CYC cycles in WAIT_RD, go to RESP with resp_err=1 and resp_data=0.
REQ-031 With the macro defined, read_vld in the same cycle as expiry SHALL win: resp_err=0 and data captured.
REQ-032 With the macro defined, resp_err SHALL be 0 for all writes and successful reads.
REQ-033 Without the macro: no counter; WAIT_RD waits indefinitely; resp_err is tied to 0.

Verification
REQ-040 Write: rw=0, addr=3'h5, wdata=8'hA3, cmd_rdy=1 -> cmd_out=12'h5A3 for one cycle; resp_vld in cycle N+2; resp_data=0.
REQ-041 Read: rw=1, addr=3'h2; cmd_rdy=1; read_vld with read_data=8'h3C three cycles later -> cmd_out=12'hA00; resp_vld the next cycle with resp_data=8'h3C and resp_err=0.
REQ-042 Backpressure: cmd_rdy=0 for 5 cycles after cmd_vld rises -> cmd_vld and cmd_out remain stable for 5 cycles; handshake on the 6th cycle; req_rdy=0 throughout.
REQ-043 Stray read_vld in IDLE with read_data=8'hFF -> no resp_vld; next write response has resp_data=0.
REQ-044 Reset in WAIT_RD, then read_vld -> no resp_vld; req_rdy=1 in the first cycle after rst deasserts.
REQ-045 With SPI_CMD_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, read with no read_vld -> resp_vld after 16 WAIT_RD cycles with resp_err=1 and resp_data=0; repeat with read_vld on the expiry cycle -> resp_err=0.

Source files
------------

// File: rtl/spi_cmd_seq_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | spi_cmd_seq_if : host request/response and SPI-master command bundle.     |
// | master = host + SPI master side, slave = sequencer. Rev 1.0               |
// +---------------------------------------------------------------------------+
interface spi_cmd_seq_if #(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8
);
  localparam int ADDR_WIDTH = CMD_WIDTH - 1 - READ_WIDTH;

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [READ_WIDTH-1:0] req_wdata;
  logic                  resp_vld;
  logic [READ_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic [CMD_WIDTH-1:0]  cmd_out;
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic                  read_vld;
  logic [READ_WIDTH-1:0] read_data;

  modport master (
    output req_vld, req_rw, req_addr, req_wdata, cmd_rdy, read_vld, read_data,
    input  req_rdy, resp_vld, resp_data, resp_err, cmd_out, cmd_vld
  );

  modport slave (
    input  req_vld, req_rw, req_addr, req_wdata, cmd_rdy, read_vld, read_data,
    output req_rdy, resp_vld, resp_data, resp_err, cmd_out, cmd_vld
  );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | spi_cmd_seq : turns host register read/write requests into SPI commands. |
// | Optional read timeout via macro SPI_CMD_SEQ_TIMEOUT_EN. Rev 1.0           |
// +---------------------------------------------------------------------------+
module spi_cmd_seq #(
  parameter int CMD_WIDTH   = 12,
  parameter int READ_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  wire logic    clk,
  input  wire logic    rst,
  spi_cmd_seq_if.slave bus
);
  localparam int ADDR_WIDTH = CMD_WIDTH - 1 - READ_WIDTH;

  if (ADDR_WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("spi_cmd_seq: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_expired;
  logic                  r_req_rdy;
  logic                  r_cmd_vld;
  logic [CMD_WIDTH-1:0]  r_cmd;
  logic                  r_resp_vld;
  logic [READ_WIDTH-1:0] r_resp_data;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cmd_rdy) begin
          w_state_nxt = r_cmd[CMD_WIDTH-1] ? WAIT_RD : RESP;
        end
      end
      WAIT_RD: begin
        if (bus.read_vld || w_expired) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_rdy   <= 1'b1;
      r_cmd_vld   <= 1'b0;
      r_cmd       <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_rdy  <= (w_state_nxt == IDLE);
      r_cmd_vld  <= (w_state_nxt == ISSUE);
      r_resp_vld <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_cmd <= {bus.req_rw, bus.req_addr,
                  (bus.req_rw ? {READ_WIDTH{1'b0}} : bus.req_wdata)};
      end
      if (r_state == ISSUE && w_state_nxt == RESP) begin
        r_resp_data <= '0;
      end else if (r_state == WAIT_RD && w_state_nxt == RESP) begin
        r_resp_data <= bus.read_vld ? bus.read_data : {READ_WIDTH{1'b0}};
      end
    end
  end

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_err;

  // Cleared while issuing so it reads 0 in the first WAIT_RD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == WAIT_RD) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (r_state == ISSUE && w_state_nxt == RESP) begin
        r_resp_err <= 1'b0;
      end else if (r_state == WAIT_RD && w_state_nxt == RESP) begin
        r_resp_err <= ~bus.read_vld;
      end
    end
  end

  assign w_expired    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.resp_err = r_resp_err;
`else
  assign w_expired    = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // Ready is forced low while reset is held, and rises as soon as it drops.
  assign bus.req_rdy   = r_req_rdy & ~rst;
  assign bus.cmd_vld   = r_cmd_vld;
  assign bus.cmd_out   = r_cmd;
  assign bus.resp_vld  = r_resp_vld;
  assign bus.resp_data = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_seq.sv
`default_nettype none
// Bench for spi_cmd_seq: directed vector table, reset/stray corner cases and
// randomized transactions checked against a transaction-level model.
module tb_spi_cmd_seq;
  localparam int CW = 12;
  localparam int RW = 8;
  localparam int AW = CW - 1 - RW;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_seq_if #(.CMD_WIDTH(CW), .READ_WIDTH(RW)) bus ();

  spi_cmd_seq #(.CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [RW-1:0] wdata;
    int            cw;
    int            rdw;
    logic [RW-1:0] rdata;
    logic [CW-1:0] exp_cmd;
    logic [RW-1:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command word: read flag in the top bit, then address, then data (reads carry no data).
  function automatic logic [CW-1:0] model_cmd(input logic rw, input int addr, input int wdata);
    int v;
    v = (rw ? (1 << (CW - 1)) : 0) + addr * (1 << RW) + (rw ? 0 : wdata);
    return v[CW-1:0];
  endfunction

  function automatic logic [RW-1:0] model_resp(input logic rw, input logic [RW-1:0] rdata);
    return rw ? rdata : '0;
  endfunction

  // Entered and left at a falling edge with the DUT idle.
  task automatic txn(input logic rw, input logic [AW-1:0] addr, input logic [RW-1:0] wdata,
                     input int cw, input int rdw, input logic [RW-1:0] rdata,
                     input logic [CW-1:0] exp_cmd, input logic [RW-1:0] exp_data,
                     input logic exp_err);
    chk("req_rdy_idle", bus.req_rdy, 1);
    bus.req_vld   = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_vld   = 1'b0;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    for (int i = 0; i <= cw; i++) begin
      chk("cmd_vld_issue", bus.cmd_vld, 1);
      chk("cmd_out", bus.cmd_out, exp_cmd);
      chk("req_rdy_busy", bus.req_rdy, 0);
      bus.cmd_rdy = (i == cw);
      @(negedge clk);
    end
    bus.cmd_rdy = 1'b0;
    chk("cmd_vld_drop", bus.cmd_vld, 0);
    if (rw) begin
      for (int j = 0; j <= rdw; j++) begin
        chk("resp_vld_wait", bus.resp_vld, 0);
        bus.read_vld  = (j == rdw);
        bus.read_data = rdata;
        @(negedge clk);
      end
      bus.read_vld  = 1'b0;
      bus.read_data = ~rdata;
    end
    chk("resp_vld", bus.resp_vld, 1);
    chk("resp_data", bus.resp_data, exp_data);
    chk("resp_err", bus.resp_err, exp_err);
    chk("req_rdy_resp", bus.req_rdy, 0);
    @(negedge clk);
    chk("resp_vld_once", bus.resp_vld, 0);
    chk("req_rdy_back", bus.req_rdy, 1);
    chk("resp_data_hold", bus.resp_data, exp_data);
  endtask

  initial begin
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [RW-1:0] r_wdata;
    logic [RW-1:0] r_rdata;

    tbl[0] = '{1'b0, 3'h5, 8'hA3, 0, 0, 8'h00, 12'h5A3, 8'h00};
    tbl[1] = '{1'b1, 3'h2, 8'h00, 0, 2, 8'h3C, 12'hA00, 8'h3C};
    tbl[2] = '{1'b0, 3'h7, 8'h11, 5, 0, 8'h00, 12'h711, 8'h00};
    tbl[3] = '{1'b1, 3'h0, 8'hFF, 1, 0, 8'h81, 12'h800, 8'h81};
    tbl[4] = '{1'b0, 3'h0, 8'h00, 0, 0, 8'h00, 12'h000, 8'h00};
    tbl[5] = '{1'b1, 3'h7, 8'h55, 3, 4, 8'hE7, 12'hF00, 8'hE7};

    bus.req_vld   = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.cmd_rdy   = 1'b0;
    bus.read_vld  = 1'b0;
    bus.read_data = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_rdy", bus.req_rdy, 0);
    chk("rst_cmd_vld", bus.cmd_vld, 0);
    chk("rst_cmd_out", bus.cmd_out, 0);
    chk("rst_resp_vld", bus.resp_vld, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    rst = 1'b0;
    #1;
    chk("req_rdy_after_rst", bus.req_rdy, 1);
    @(negedge clk);

    foreach (tbl[k]) begin
      txn(tbl[k].rw, tbl[k].addr, tbl[k].wdata, tbl[k].cw, tbl[k].rdw, tbl[k].rdata,
          tbl[k].exp_cmd, tbl[k].exp_data, 1'b0);
    end

    // Stray read_vld while idle must not produce a response or data
    bus.read_vld  = 1'b1;
    bus.read_data = 8'hFF;
    @(negedge clk);
    bus.read_vld  = 1'b0;
    chk("stray_resp_vld", bus.resp_vld, 0);
    @(negedge clk);
    chk("stray_resp_vld2", bus.resp_vld, 0);
    txn(1'b0, 3'h1, 8'h0F, 0, 0, 8'h00, 12'h10F, 8'h00, 1'b0);

    // Reset while a command is stalled in ISSUE
    bus.req_vld = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 3'h3;
    @(negedge clk);
    bus.req_vld = 1'b0;
    chk("issue_before_rst", bus.cmd_vld, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("issue_rst_req_rdy", bus.req_rdy, 0);
    chk("issue_rst_cmd_vld", bus.cmd_vld, 0);
    chk("issue_rst_cmd_out", bus.cmd_out, 0);
    rst = 1'b0;
    #1;
    chk("issue_rst_req_rdy_after", bus.req_rdy, 1);
    @(negedge clk);
    chk("issue_rst_no_resp", bus.resp_vld, 0);
    chk("issue_rst_cmd_idle", bus.cmd_vld, 0);

    // Reset while waiting for read data, then late read data is ignored
    bus.req_vld = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 3'h4;
    @(negedge clk);
    bus.req_vld = 1'b0;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    chk("wait_cmd_vld", bus.cmd_vld, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wait_rst_req_rdy", bus.req_rdy, 1);
    bus.read_vld  = 1'b1;
    bus.read_data = 8'h77;
    @(negedge clk);
    bus.read_vld = 1'b0;
    chk("wait_rst_no_resp", bus.resp_vld, 0);
    @(negedge clk);
    chk("wait_rst_no_resp2", bus.resp_vld, 0);
    chk("wait_rst_resp_data", bus.resp_data, 0);
    chk("wait_rst_req_rdy2", bus.req_rdy, 1);

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
    // Read with no data: response after TO cycles in WAIT_RD, flagged as error
    bus.req_vld = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 3'h6;
    @(negedge clk);
    bus.req_vld = 1'b0;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    for (int c = 0; c < TO; c++) begin
      chk("to_resp_vld_wait", bus.resp_vld, 0);
      @(negedge clk);
    end
    chk("to_resp_vld", bus.resp_vld, 1);
    chk("to_resp_err", bus.resp_err, 1);
    chk("to_resp_data", bus.resp_data, 0);
    @(negedge clk);
    chk("to_req_rdy", bus.req_rdy, 1);
    chk("to_err_hold", bus.resp_err, 1);
    // Data on the expiry cycle wins
    txn(1'b1, 3'h6, 8'h00, 0, TO - 1, 8'h5A, 12'hE00, 8'h5A, 1'b0);
`endif

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.read_vld  = $urandom_range(0, 1);
        bus.read_data = RW'($urandom);
        @(negedge clk);
        bus.read_vld = 1'b0;
        chk("rand_idle_resp_vld", bus.resp_vld, 0);
      end
      r_rw    = 1'($urandom_range(0, 1));
      r_addr  = AW'($urandom);
      r_wdata = RW'($urandom);
      r_rdata = RW'($urandom);
      txn(r_rw, r_addr, r_wdata, $urandom_range(0, 3), $urandom_range(0, 10), r_rdata,
          model_cmd(r_rw, int'(r_addr), int'(r_wdata)), model_resp(r_rw, r_rdata), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
